// File: rtl/my_dist_pkg.sv
// Shared constants and types for the 8-way word distributor and its lane FIFOs.
package my_dist_pkg;
  localparam int LANES  = 8;
  localparam int SEL_W  = 3;
  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LANES-1:0]  lane_vec_t;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(LANES * depth + 1);
  endfunction

  function automatic logic [SEL_W:0] popcnt(input lane_vec_t v);
    logic [SEL_W:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {{SEL_W{1'b0}}, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/my_lane_fifo.sv
// Single-lane synchronous FIFO; head holds its last popped value while the lane is empty.
module my_lane_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
  assign head_o  = valid_o ? mem_q[rd_q] : last_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = AW'(wr_q + 1'b1);
    if (pop_i)  rd_d = AW'(rd_q + 1'b1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = CW'(cnt_q + 1'b1);
      2'b01:   cnt_d = CW'(cnt_q - 1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[wr_q] <= din_i;
      if (pop_i)  last_q <= mem_q[rd_q];
    end
  end
endmodule

// File: rtl/my_dist8way16.sv
// 1-to-8 word distributor with per-lane FIFOs, status reductions and total occupancy.
// Optional round-robin destination mode is built when DIST8_RR_EN is defined.
module my_dist8way16
  import my_dist_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(8 * DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES-1:0][WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_valid,
  input  logic [LANES-1:0]            out_ready,
  output logic                        any_valid,
  output logic                        all_empty,
`ifdef DIST8_RR_EN
  input  logic                        rr_mode,
`endif
  output logic [OCC_W-1:0]            occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SEL_W-1:0] dst;
  lane_vec_t        push_vec, pop_vec, full_vec, valid_vec;
  logic [WIDTH-1:0] heads [LANES];
  logic [CW-1:0]    counts [LANES];
  logic             accept;
  logic [OCC_W-1:0] occ_q, occ_d;

`ifdef DIST8_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  assign dst   = rr_mode ? ptr_q : in_sel;
  // Pointer only moves on pushes it actually steered.
  assign ptr_d = (rr_mode && accept) ? SEL_W'(ptr_q + 1'b1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign dst = in_sel;
`endif

  // Ready depends only on registered lane state, never on out_ready.
  assign in_ready = ~full_vec[dst];
  assign accept   = in_valid & in_ready;

  always_comb begin
    push_vec = '0;
    push_vec[dst] = accept;
  end

  assign pop_vec = valid_vec & out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    my_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_vec[k]),
      .pop_i   (pop_vec[k]),
      .din_i   (in_data),
      .full_o  (full_vec[k]),
      .valid_o (valid_vec[k]),
      .head_o  (heads[k]),
      .count_o (counts[k])
    );
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) out_data[k] = heads[k];
  end

  assign out_valid = valid_vec;
  assign any_valid = |valid_vec;
  assign all_empty = ~|valid_vec;

  assign occ_d = OCC_W'(occ_q + OCC_W'(accept) - OCC_W'(popcnt(pop_vec)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;

  logic unused_counts;
  always_comb begin
    unused_counts = 1'b0;
    for (int k = 0; k < LANES; k++) unused_counts = unused_counts ^ (^counts[k]);
  end
endmodule
